// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for pipe_stage_reg: upstream valid/ready with ctrl and payload,
// downstream valid/ready with gated ctrl and payload, flush and the stall counter.
// master = the environment around the stage, slave = the stage itself.
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 160,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [PAYLOAD_W-1:0] out_data;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register carrying an opaque payload and a
// control vector under valid/ready, with synchronous flush and a saturating
// stall-cycle counter. Control is forced to zero whenever the stage holds a bubble.
//
// Build option PIPE_STAGE_SKID_EN: when defined, a second (skid) register is added
// so in_ready depends only on local state, breaking the out_ready->in_ready path.
//
// Skid FSM (PIPE_STAGE_SKID_EN only):
//   state | meaning
//   EMPTY | no word held, out_valid=0
//   ONE   | one word in main register
//   TWO   | main and skid both hold words, in_ready=0
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 160,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input logic            clk,
    input logic            reset,
    pipe_stage_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 in_ready;
    logic                 accept;
    logic                 deliver;
    logic                 out_vld;
    logic [CTRL_W-1:0]    main_ctrl_q;
    logic [PAYLOAD_W-1:0] main_data_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

`ifdef PIPE_STAGE_SKID_EN

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CTRL_W-1:0]    main_ctrl_d;
    logic [PAYLOAD_W-1:0] main_data_d;
    logic [CTRL_W-1:0]    skid_ctrl_q, skid_ctrl_d;
    logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;

    assign out_vld  = (state_q != EMPTY);
    assign in_ready = !bus.flush && (state_q != TWO);
    assign accept   = bus.in_valid && in_ready;
    assign deliver  = out_vld && bus.out_ready;

    // Next-state and register steering for the two-entry buffer; flush empties both.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_ctrl_d = bus.in_ctrl;
                        main_data_d = bus.in_data;
                    end else if (accept) begin
                        state_d     = TWO;
                        skid_ctrl_d = bus.in_ctrl;
                        skid_data_d = bus.in_data;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Buffer state and both entries; reset discards anything held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`else

    logic                 valid_q, valid_d;
    logic [CTRL_W-1:0]    main_ctrl_d;
    logic [PAYLOAD_W-1:0] main_data_d;

    assign out_vld  = valid_q;
    assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign deliver  = valid_q && bus.out_ready;

    // Single register: load on accept (even while delivering), empty on delivery or flush.
    always_comb begin
        valid_d     = valid_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
        end else if (deliver) begin
            valid_d = 1'b0;
        end
    end

    // Holding register; payload keeps its last value while the stage is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            valid_q     <= valid_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

`endif

    // Count stalled cycles (held word refused downstream), saturating; flush cycles do not count.
    always_comb begin
        cnt_d = cnt_q;
        if (out_vld && !bus.out_ready && !bus.flush && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_vld;
    assign bus.out_ctrl  = out_vld ? main_ctrl_q : '0;
    assign bus.out_data  = main_data_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4 so saturation is reachable quickly).
// Inputs are driven 1 time unit after the rising edge and outputs are checked there too.
module tb_pipe_stage_reg;

    localparam int PAYLOAD_W = 160;
    localparam int CTRL_W    = 8;
    localparam int CNT_W     = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pipe_stage_reg_if #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs,
                       input logic [PAYLOAD_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", PAYLOAD_W'(bus.out_valid), 0);
        chk("rst_out_ctrl",  PAYLOAD_W'(bus.out_ctrl),  0);
        chk("rst_out_data",  bus.out_data,              0);
        chk("rst_stall_cnt", PAYLOAD_W'(bus.stall_cnt), 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", PAYLOAD_W'(bus.in_ready), 1);

        // Streaming 1..8 with one-cycle latency and no gaps
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = PAYLOAD_W'(i);
            bus.in_ctrl  = CTRL_W'(8'h10 + i);
            tick();
            chk("stream_valid", PAYLOAD_W'(bus.out_valid), 1);
            chk("stream_data",  bus.out_data,              PAYLOAD_W'(i));
            chk("stream_ctrl",  PAYLOAD_W'(bus.out_ctrl),  PAYLOAD_W'(8'h10 + i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", PAYLOAD_W'(bus.out_valid), 0);
        chk("drain_ctrl",  PAYLOAD_W'(bus.out_ctrl),  0);
        chk("drain_data",  bus.out_data,              8);
        chk("stream_cnt",  PAYLOAD_W'(bus.stall_cnt), 0);

        // Bubble gating: ctrl presented without valid never shows
        bus.in_ctrl = 8'hFF;
        tick();
        chk("bubble_ctrl",  PAYLOAD_W'(bus.out_ctrl),  0);
        chk("bubble_valid", PAYLOAD_W'(bus.out_valid), 0);

        // Backpressure on 0xA5, offering 0xA6 meanwhile
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_ctrl  = 8'h3C;
        tick();
        chk("bp_load_data", bus.out_data, 8'hA5);
        bus.out_ready = 1'b0;
        bus.in_data   = 8'hA6;
        bus.in_ctrl   = 8'h3D;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_in_ready_first", PAYLOAD_W'(bus.in_ready), 1);
`else
        chk("bp_in_ready_first", PAYLOAD_W'(bus.in_ready), 0);
`endif
        for (int i = 0; i < 5; i++) tick();
        chk("bp_hold_data", bus.out_data,              8'hA5);
        chk("bp_hold_ctrl", PAYLOAD_W'(bus.out_ctrl),  8'h3C);
        chk("bp_stall_cnt", PAYLOAD_W'(bus.stall_cnt), 5);
        chk("bp_in_ready",  PAYLOAD_W'(bus.in_ready),  0);
        bus.out_ready = 1'b1;
        #1;
`ifndef PIPE_STAGE_SKID_EN
        chk("bp_ready_follow", PAYLOAD_W'(bus.in_ready), 1);
`endif
        tick();
        bus.in_valid = 1'b0;
        chk("bp_second_data", bus.out_data,             8'hA6);
        chk("bp_second_ctrl", PAYLOAD_W'(bus.out_ctrl), 8'h3D);
        tick();
        chk("bp_empty",      PAYLOAD_W'(bus.out_valid), 0);
        chk("bp_cnt_kept",   PAYLOAD_W'(bus.stall_cnt), 5);

        // Saturation: 20 stall cycles from a count of 5
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        bus.in_ctrl  = 8'h01;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_mid", PAYLOAD_W'(bus.stall_cnt), 14);
        for (int i = 0; i < 11; i++) tick();
        chk("sat_top", PAYLOAD_W'(bus.stall_cnt), 15);
`ifndef PIPE_STAGE_SKID_EN
        chk("sat_rdy_lo", PAYLOAD_W'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        #1;
        chk("sat_rdy_hi", PAYLOAD_W'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        #1;
        chk("sat_rdy_lo2", PAYLOAD_W'(bus.in_ready), 0);
`else
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        bus.in_ctrl  = 8'h02;
        tick();
        chk("skid_full_rdy", PAYLOAD_W'(bus.in_ready), 0);
`endif

        // Flush a full stage while offering 0x77
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus.in_ctrl  = 8'h77;
        #1;
        chk("flush_in_ready", PAYLOAD_W'(bus.in_ready), 0);
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_valid", PAYLOAD_W'(bus.out_valid), 0);
        chk("flush_ctrl",  PAYLOAD_W'(bus.out_ctrl),  0);
        chk("flush_cnt",   PAYLOAD_W'(bus.stall_cnt), 15);
        tick();
        chk("flush_no77", PAYLOAD_W'(bus.out_valid), 0);

        // Reset mid-transfer with a word held and stalled
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.in_ctrl  = 8'h0F;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("pre_rst_valid", PAYLOAD_W'(bus.out_valid), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", PAYLOAD_W'(bus.out_valid), 0);
        chk("mid_rst_ctrl",  PAYLOAD_W'(bus.out_ctrl),  0);
        chk("mid_rst_cnt",   PAYLOAD_W'(bus.stall_cnt), 0);
        chk("mid_rst_data",  bus.out_data,              0);
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_ready", PAYLOAD_W'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        bus.in_ctrl   = 8'h09;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_data", bus.out_data,             8'h99);
        chk("post_rst_ctrl", PAYLOAD_W'(bus.out_ctrl), 8'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
